// File: rtl/matrix_operand_feeder.sv
// Operand buffer feeding matrix_mul: host loads A/B row-major into two banks,
// then a rising ren streams the selected bank one element per clock.
module matrix_operand_feeder #(
    parameter int DATA_W   = 16,
    parameter int MAX_SIZE = 6
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [3:0]        sizes_i,
    input  logic              ld_valid_i,
    input  logic              ld_sel_i,
    input  logic [DATA_W-1:0] ld_data_i,
    output logic              ld_ready_o,
    output logic              a_loaded_o,
    output logic              b_loaded_o,
    input  logic              clear_i,
    input  logic              ren_i,
    input  logic              raddr_i,
    output logic [DATA_W-1:0] rdata_o,
    output logic              rvalid_o,
    output logic              busy_o
);
    localparam int DEPTH  = MAX_SIZE * MAX_SIZE;
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic {IDLE, STREAM} state_e;

    state_e                   state_q, state_d;
    logic                     sel_q, sel_d;
    logic [CNT_W-1:0]         idx_q, idx_d;
    logic [DATA_W-1:0]        rdata_q, rdata_d;
    logic                     rvalid_q, rvalid_d;
    logic                     busy_q, busy_d;
    logic                     ren_q;
    logic [1:0][CNT_W-1:0]    cnt_q, cnt_d;
    logic [1:0]               loaded_q, loaded_d;
    logic [DATA_W-1:0]        bank_q [2][DEPTH];

    logic [3:0]               n_eff;
    logic [CNT_W-1:0]         nn;
    logic                     ld_fire;

    // Effective size is clamped, never latched: a size change takes effect immediately.
    assign n_eff = (sizes_i > 4'(MAX_SIZE)) ? 4'(MAX_SIZE) : sizes_i;
    assign nn    = CNT_W'(n_eff) * CNT_W'(n_eff);

    assign ld_ready_o = !busy_q && !rst_i && !loaded_q[ld_sel_i] && (nn != '0);
    assign ld_fire    = ld_valid_i && ld_ready_o && !clear_i;

    assign a_loaded_o = loaded_q[0];
    assign b_loaded_o = loaded_q[1];
    assign rdata_o    = rdata_q;
    assign rvalid_o   = rvalid_q;
    assign busy_o     = busy_q;

    // Storage is deliberately left out of reset; stale words remain readable.
    always_ff @(posedge clk_i) begin
        if (ld_fire)
            bank_q[ld_sel_i][cnt_q[ld_sel_i][ADDR_W-1:0]] <= ld_data_i;
    end

    always_comb begin
        cnt_d    = cnt_q;
        loaded_d = loaded_q;
        if (clear_i) begin
            cnt_d    = '0;
            loaded_d = '0;
        end else if (ld_fire) begin
            cnt_d[ld_sel_i] = cnt_q[ld_sel_i] + CNT_W'(1);
            if (cnt_d[ld_sel_i] >= nn)
                loaded_d[ld_sel_i] = 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        idx_d    = idx_q;
        rdata_d  = rdata_q;
        rvalid_d = 1'b0;
        busy_d   = busy_q;
        case (state_q)
            IDLE: begin
                if (ren_i && !ren_q && (nn != '0)) begin
                    state_d = STREAM;
                    sel_d   = raddr_i;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            STREAM: begin
                // One extra cycle after the last element lets busy fall with rvalid.
                if (idx_q < nn) begin
                    rdata_d  = bank_q[sel_q][idx_q[ADDR_W-1:0]];
                    rvalid_d = 1'b1;
                    idx_d    = idx_q + CNT_W'(1);
                end else begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            sel_q    <= 1'b0;
            idx_q    <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            busy_q   <= 1'b0;
            ren_q    <= 1'b0;
            cnt_q    <= '0;
            loaded_q <= '0;
        end else begin
            state_q  <= state_d;
            sel_q    <= sel_d;
            idx_q    <= idx_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            busy_q   <= busy_d;
            ren_q    <= ren_i;
            cnt_q    <= cnt_d;
            loaded_q <= loaded_d;
        end
    end
endmodule

// File: tb/tb_matrix_operand_feeder.sv
// Randomized scenario bench for matrix_operand_feeder with a behavioural bank model.
module tb_matrix_operand_feeder;
    localparam int DATA_W = 16;
    localparam int MAXS   = 6;

    logic              clk = 1'b0;
    logic              rst;
    logic [3:0]        sizes;
    logic              ld_valid, ld_sel;
    logic [DATA_W-1:0] ld_data;
    logic              ld_ready, a_loaded, b_loaded;
    logic              clear, ren, raddr;
    logic [DATA_W-1:0] rdata;
    logic              rvalid, busy;

    int errors = 0;
    int checks = 0;

    logic [DATA_W-1:0] bank_m [2][MAXS*MAXS];
    int                cnt_m [2];
    bit                loaded_m [2];

    matrix_operand_feeder #(.DATA_W(DATA_W), .MAX_SIZE(MAXS)) dut (
        .clk_i(clk), .rst_i(rst), .sizes_i(sizes),
        .ld_valid_i(ld_valid), .ld_sel_i(ld_sel), .ld_data_i(ld_data),
        .ld_ready_o(ld_ready), .a_loaded_o(a_loaded), .b_loaded_o(b_loaded),
        .clear_i(clear), .ren_i(ren), .raddr_i(raddr),
        .rdata_o(rdata), .rvalid_o(rvalid), .busy_o(busy)
    );

    always #5 clk = ~clk;

    function automatic int nn_m();
        int n;
        n = (int'(sizes) > MAXS) ? MAXS : int'(sizes);
        return n * n;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One load attempt while idle; model decides whether it is accepted.
    task automatic load(input bit sel, input logic [DATA_W-1:0] d);
        bit exp_rdy;
        exp_rdy  = !loaded_m[sel] && (nn_m() != 0);
        ld_valid = 1'b1; ld_sel = sel; ld_data = d;
        #1;
        checks++;
        if (ld_ready !== exp_rdy) begin
            errors++;
            $display("FAIL ld_ready sel=%0d cnt=%0d: got %b expected %b", sel, cnt_m[sel], ld_ready, exp_rdy);
        end
        tick();
        if (exp_rdy) begin
            bank_m[sel][cnt_m[sel]] = d;
            cnt_m[sel]++;
            if (cnt_m[sel] >= nn_m()) loaded_m[sel] = 1'b1;
        end
        checks++;
        if ({a_loaded, b_loaded} !== {loaded_m[0], loaded_m[1]}) begin
            errors++;
            $display("FAIL loaded_flags: got %b%b expected %b%b", a_loaded, b_loaded, loaded_m[0], loaded_m[1]);
        end
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        cnt_m = '{0, 0};
        loaded_m = '{0, 0};
        checks++;
        if ({a_loaded, b_loaded} !== 2'b00) begin
            errors++;
            $display("FAIL clear_flags: got %b%b expected 00", a_loaded, b_loaded);
        end
    endtask

    // Rising ren with ren held for `hold` sampled edges; checks every cycle of the stream and after.
    task automatic do_stream(input bit sel, input int hold, input bit try_load);
        int n2;
        logic [DATA_W-1:0] last;
        n2 = nn_m();
        last = rdata;
        ren = 1'b1; raddr = sel;
        tick();
        checks++;
        if (busy !== (n2 != 0)) begin
            errors++;
            $display("FAIL stream_start_busy: got %b expected %b", busy, n2 != 0);
        end
        for (int c = 0; c < n2 + hold + 2; c++) begin
            ren = ((c + 1) < hold);
            if (try_load && c < n2) begin
                ld_valid = 1'b1; ld_sel = !sel; ld_data = 16'h5a5a;
                #1;
                checks++;
                if (ld_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL ld_ready_busy[%0d]: got %b expected 0", c, ld_ready);
                end
            end else begin
                ld_valid = 1'b0;
            end
            tick();
            checks++;
            if (c < n2) begin
                last = bank_m[sel][c];
                if (rvalid !== 1'b1 || rdata !== last || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL stream_elem[%0d] sel=%0d: got v=%b b=%b d=%0d expected v=1 b=1 d=%0d",
                             c, sel, rvalid, busy, $signed(rdata), $signed(last));
                end
            end else if (rvalid !== 1'b0 || busy !== 1'b0 || rdata !== last) begin
                errors++;
                $display("FAIL stream_tail[%0d]: got v=%b b=%b d=%0d expected v=0 b=0 d=%0d",
                         c, rvalid, busy, $signed(rdata), $signed(last));
            end
        end
        ren = 1'b0; ld_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; sizes = 4'd6; ld_valid = 0; ld_sel = 0; ld_data = '0;
        clear = 0; ren = 0; raddr = 0;
        tick(); tick();
        checks++;
        if ({rvalid, busy, a_loaded, b_loaded, ld_ready} !== 5'b0 || rdata !== '0) begin
            errors++;
            $display("FAIL reset_state: got v=%b b=%b al=%b bl=%b rdy=%b d=%0d expected all 0",
                     rvalid, busy, a_loaded, b_loaded, ld_ready, rdata);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (ld_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: got %b expected 1", ld_ready);
        end
        cnt_m = '{0, 0};
        loaded_m = '{0, 0};
    endtask

    task automatic test_load_stream_a();
        sizes = 4'd6;
        for (int i = 1; i <= 36; i++) load(1'b0, DATA_W'(i));
        for (int i = 1; i <= 36; i++) load(1'b1, DATA_W'(-i));
        ld_valid = 1'b0;
        do_stream(1'b0, 1, 1'b0);
    endtask

    task automatic test_stream_b_held();
        sizes = 4'd6;
        do_stream(1'b1, 50, 1'b0);
    endtask

    task automatic test_clamp_zero();
        sizes = 4'd9;
        do_clear();
        for (int i = 0; i < 37; i++) load(1'b0, DATA_W'($urandom));
        ld_valid = 1'b0;
        do_stream(1'b0, 1, 1'b0);
        sizes = 4'd0;
        load(1'b1, 16'h1234);
        ld_valid = 1'b0;
        do_stream(1'b1, 2, 1'b0);
    endtask

    task automatic test_overflow_busy();
        sizes = 4'd2;
        do_clear();
        for (int i = 5; i <= 9; i++) load(1'b0, DATA_W'(i));
        ld_valid = 1'b0;
        do_stream(1'b0, 1, 1'b1);
        for (int i = 0; i < 4; i++) load(1'b1, DATA_W'(100 + i));
        ld_valid = 1'b0;
        do_stream(1'b1, 1, 1'b0);
    endtask

    task automatic test_reset_mid_stream();
        sizes = 4'd6;
        do_clear();
        for (int i = 0; i < 36; i++) load(1'b0, DATA_W'($urandom));
        ld_valid = 1'b0;
        ren = 1'b1; raddr = 1'b0;
        tick();
        ren = 1'b0;
        for (int i = 0; i <= 10; i++) begin
            tick();
            checks++;
            if (rvalid !== 1'b1 || rdata !== bank_m[0][i]) begin
                errors++;
                $display("FAIL pre_reset_elem[%0d]: got v=%b d=%0d expected v=1 d=%0d",
                         i, rvalid, $signed(rdata), $signed(bank_m[0][i]));
            end
        end
        rst = 1'b1;
        #1;
        checks++;
        if (ld_ready !== 1'b0) begin
            errors++;
            $display("FAIL ld_ready_in_reset: got %b expected 0", ld_ready);
        end
        tick();
        rst = 1'b0;
        cnt_m = '{0, 0};
        loaded_m = '{0, 0};
        checks++;
        if (rvalid !== 1'b0 || rdata !== '0 || busy !== 1'b0 || a_loaded !== 1'b0) begin
            errors++;
            $display("FAIL mid_stream_reset: got v=%b d=%0d b=%b al=%b expected 0 0 0 0",
                     rvalid, rdata, busy, a_loaded);
        end
        for (int i = 0; i < 36; i++) load(1'b0, DATA_W'($urandom));
        ld_valid = 1'b0;
        do_stream(1'b0, 1, 1'b0);
    endtask

    task automatic test_clear_with_load();
        sizes = 4'd2;
        do_clear();
        load(1'b0, 16'h0aa1);
        load(1'b0, 16'h0aa2);
        clear = 1'b1; ld_valid = 1'b1; ld_sel = 1'b0; ld_data = 16'h7777;
        tick();
        clear = 1'b0; ld_valid = 1'b0;
        cnt_m = '{0, 0};
        loaded_m = '{0, 0};
        checks++;
        if (a_loaded !== 1'b0) begin
            errors++;
            $display("FAIL clear_load_flag: got %b expected 0", a_loaded);
        end
        for (int i = 0; i < 4; i++) load(1'b0, DATA_W'(16'h0c00 + i));
        ld_valid = 1'b0;
        do_stream(1'b0, 1, 1'b0);
    endtask

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            sizes = 4'($urandom_range(1, 9));
            do_clear();
            for (int k = 0; k < int'($urandom_range(0, 45)); k++) begin
                if ($urandom_range(0, 3) == 0) begin
                    ld_valid = 1'b0;
                    tick();
                end else begin
                    load(1'($urandom), DATA_W'($urandom));
                end
            end
            ld_valid = 1'b0;
            do_stream(1'($urandom), int'($urandom_range(1, 4)), 1'($urandom));
        end
    endtask

    initial begin
        test_reset();
        test_load_stream_a();
        test_stream_b_held();
        test_clamp_zero();
        test_overflow_busy();
        test_reset_mid_stream();
        test_clear_with_load();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
